// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package adder_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  // ID width never collapses to zero, even for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, adder and response signals of the adder-sharing arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned N       = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_A;
  logic [NUM_REQ*N-1:0] req_B;
  logic [NUM_REQ-1:0]   req_Cin;
  logic                 add_start;
  logic [N-1:0]         add_A;
  logic [N-1:0]         add_B;
  logic                 add_Cin;
  logic [N-1:0]         add_S;
  logic                 add_Cout;
  logic                 add_done;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [N-1:0]         resp_S;
  logic                 resp_Cout;
  logic                 resp_err;
  logic                 busy;

  modport master (
    input  req_valid, req_A, req_B, req_Cin, add_S, add_Cout, add_done, resp_ready,
    output req_ready, add_start, add_A, add_B, add_Cin,
           resp_valid, resp_id, resp_S, resp_Cout, resp_err, busy
  );

  modport slave (
    output req_valid, req_A, req_B, req_Cin, add_S, add_Cout, add_done, resp_ready,
    input  req_ready, add_start, add_A, add_B, add_Cin,
           resp_valid, resp_id, resp_S, resp_Cout, resp_err, busy
  );
endinterface

// File: rtl/adder_share_arbiter_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);
  int unsigned     w_pos;
  logic [ID_W-1:0] w_pos_id;
  logic            w_found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    w_found  = 1'b0;
    w_pos    = 0;
    w_pos_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = 32'(ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_pos_id = ID_W'(w_pos);
      if (!w_found && req[w_pos_id]) begin
        w_found       = 1'b1;
        gnt[w_pos_id] = 1'b1;
        gnt_idx       = w_pos_id;
      end
    end
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one start/done adder among NUM_REQ requesters,
// with a watchdog that turns a missing done into an error response.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ),
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                   CLOCK_50,
  input logic                   rst,
  adder_share_arbiter_if.master bus
);
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TMAX    = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr, r_gnt_id, w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt, w_req_ready;
  logic [CNT_W-1:0]   r_tcnt;
  logic [N-1:0]       r_add_A, r_add_B, r_resp_S, w_sel_A, w_sel_B;
  logic               r_add_Cin, r_resp_valid, r_resp_Cout, r_resp_err, w_sel_Cin;
  logic               w_accept, w_take_done, w_timeout, w_resp_hs, w_add_start;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_idx(w_gnt_idx)
  );

  // Operand select driven by the one-hot grant, not by the encoded index.
  always_comb begin
    w_sel_A   = '0;
    w_sel_B   = '0;
    w_sel_Cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_A   = bus.req_A[i*N +: N];
        w_sel_B   = bus.req_B[i*N +: N];
        w_sel_Cin = bus.req_Cin[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_add_start = 1'b0;
    w_accept    = 1'b0;
    w_take_done = 1'b0;
    w_timeout   = 1'b0;
    w_resp_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = rst ? '0 : w_gnt;
        if (!rst && (w_gnt != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_add_start = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.add_done) begin
          w_take_done = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_tcnt == TMAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_resp_valid && bus.resp_ready) begin
          w_resp_hs   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_tcnt       <= '0;
      r_add_A      <= '0;
      r_add_B      <= '0;
      r_add_Cin    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_S     <= '0;
      r_resp_Cout  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_add_A   <= w_sel_A;
        r_add_B   <= w_sel_B;
        r_add_Cin <= w_sel_Cin;
        r_gnt_id  <= w_gnt_idx;
      end
      if (r_state == ST_ISSUE)     r_tcnt <= '0;
      else if (r_state == ST_WAIT) r_tcnt <= r_tcnt + CNT_W'(1);
      // done has priority over an expiring watchdog in the same cycle
      if (w_take_done) begin
        r_resp_valid <= 1'b1;
        r_resp_S     <= bus.add_S;
        r_resp_Cout  <= bus.add_Cout;
        r_resp_err   <= 1'b0;
      end else if (w_timeout) begin
        r_resp_valid <= 1'b1;
        r_resp_S     <= '0;
        r_resp_Cout  <= 1'b0;
        r_resp_err   <= 1'b1;
      end
      if (w_resp_hs) begin
        r_resp_valid <= 1'b0;
        r_rr_ptr     <= (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + ID_W'(1);
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.add_start  = w_add_start;
  assign bus.add_A      = r_add_A;
  assign bus.add_B      = r_add_B;
  assign bus.add_Cin    = r_add_Cin;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_gnt_id;
  assign bus.resp_S     = r_resp_S;
  assign bus.resp_Cout  = r_resp_Cout;
  assign bus.resp_err   = r_resp_err;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter with a behavioural digit-serial adder stub.
module tb_adder_share_arbiter;
  localparam int unsigned N       = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned ITER    = 3;
  localparam int unsigned LAT_OK  = ITER + 2;
  localparam int unsigned LAT_TO  = TIMEOUT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) ifc ();

  adder_share_arbiter #(
    .N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (ifc)
  );

  typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic cin; } op_t;
  typedef struct { logic [ID_W-1:0] id; logic [N-1:0] s; logic cout; logic err; int unsigned lat; } exp_t;

  op_t  q_req[NUM_REQ][$];
  exp_t q_exp[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder stub: samples start, spends ITER active edges, then pulses done.
  logic            dead = 1'b0, inj_done = 1'b0, stub_done = 1'b0, stub_Cout = 1'b0, lat_C = 1'b0;
  logic [N-1:0]    stub_S = '0, lat_A = '0, lat_B = '0;
  int unsigned     stub_cnt = 0;
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (rst) begin
      stub_cnt <= 0;
    end else if (ifc.add_start) begin
      stub_cnt <= ITER;
      lat_A    <= ifc.add_A;
      lat_B    <= ifc.add_B;
      lat_C    <= ifc.add_Cin;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !dead) begin
        {stub_Cout, stub_S} <= {1'b0, lat_A} + {1'b0, lat_B} + (N+1)'(lat_C);
        stub_done           <= 1'b1;
      end
    end
  end
  assign ifc.add_S    = stub_S;
  assign ifc.add_Cout = stub_Cout;
  assign ifc.add_done = stub_done | inj_done;

  // Driver: presents each requester's queue head, retires it after its handshake.
  logic [NUM_REQ-1:0] acc_vec  = '0;
  logic               rr_rand  = 1'b0;
  logic               rr_fixed = 1'b1;
  initial begin
    logic [NUM_REQ-1:0]   v, c;
    logic [NUM_REQ*N-1:0] a, b;
    ifc.req_valid = '0; ifc.req_A = '0; ifc.req_B = '0; ifc.req_Cin = '0; ifc.resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (acc_vec[i] && q_req[i].size() != 0) q_req[i].delete(0);
      acc_vec = '0;
      v = '0; c = '0; a = '0; b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q_req[i].size() != 0) begin
          v[i] = 1'b1;
          a[i*N +: N] = q_req[i][0].a;
          b[i*N +: N] = q_req[i][0].b;
          c[i] = q_req[i][0].cin;
        end
      end
      ifc.req_valid  = v; ifc.req_A = a; ifc.req_B = b; ifc.req_Cin = c;
      ifc.resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    end
  end

  function automatic logic [ID_W-1:0] model_pick(input logic [NUM_REQ-1:0] v, input int unsigned p);
    logic [ID_W-1:0] j;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = ID_W'((p + k) % NUM_REQ);
      if (v[j]) return j;
    end
    return '0;
  endfunction

  // Monitor: pushes expectations at accept, checks start and responses.
  int unsigned     m_ptr = 0;
  int              acc_cyc = -100;
  logic            inflight = 1'b0, prev_rv = 1'b0, prev_ready = 1'b0;
  op_t             cur;
  exp_t            held;
  logic [ID_W-1:0] last_id = '0;
  logic [N-1:0]    last_S = '0;
  logic            last_Cout = 1'b0, last_err = 1'b0;

  always @(negedge clk) begin
    logic [ID_W-1:0]    pick;
    logic [NUM_REQ-1:0] acc;
    logic [N:0]         sum;
    logic               exp_start;
    exp_t               e;
    if (rst) begin
      prev_rv = 1'b0; prev_ready = 1'b0;
    end else begin
      if (!ifc.busy && ifc.req_valid != '0)
        chk("grant_when_idle", 32'(ifc.req_ready != '0), 32'd1);
      if (ifc.req_ready != '0) begin
        pick = model_pick(ifc.req_valid, m_ptr);
        chk("ready_is_rr_pick", 32'(ifc.req_ready), 32'd1 << pick);
        chk("ready_only_idle_pulse", {30'd0, ifc.busy, prev_ready}, 32'd0);
        acc = ifc.req_ready & ifc.req_valid;
        if (acc[pick] && q_req[pick].size() != 0) begin
          acc_vec = acc;
          cur  = q_req[pick][0];
          sum  = {1'b0, cur.a} + {1'b0, cur.b} + (N+1)'(cur.cin);
          e.id = pick; e.err = dead;
          e.s  = dead ? '0 : sum[N-1:0];
          e.cout = dead ? 1'b0 : sum[N];
          e.lat  = dead ? LAT_TO : LAT_OK;
          q_exp.push_back(e);
          acc_cyc = cyc; inflight = 1'b1;
        end
      end
      prev_ready = (ifc.req_ready != '0);
      exp_start = inflight && (cyc == acc_cyc + 1);
      if (ifc.add_start || exp_start) begin
        chk("add_start", 32'(ifc.add_start), 32'(exp_start));
        if (exp_start) chk("add_operands", {15'd0, ifc.add_Cin, ifc.add_A}, {15'd0, cur.cin, cur.a});
        if (exp_start) chk("add_B", 32'(ifc.add_B), 32'(cur.b));
      end
      if (ifc.resp_valid) begin
        if (!prev_rv) begin
          if (q_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_resp: got id=%0d S=0x%0h err=%0d expected no response", ifc.resp_id, ifc.resp_S, ifc.resp_err);
          end else begin
            e = q_exp[0];
            chk("resp_id", 32'(ifc.resp_id), 32'(e.id));
            chk("resp_S", 32'(ifc.resp_S), 32'(e.s));
            chk("resp_Cout", 32'(ifc.resp_Cout), 32'(e.cout));
            chk("resp_err", 32'(ifc.resp_err), 32'(e.err));
            chk("latency", 32'(cyc - acc_cyc - 1), e.lat);
          end
          held.id = ifc.resp_id; held.s = ifc.resp_S; held.cout = ifc.resp_Cout; held.err = ifc.resp_err;
          last_id = ifc.resp_id; last_S = ifc.resp_S; last_Cout = ifc.resp_Cout; last_err = ifc.resp_err;
          inflight = 1'b0;
        end else begin
          chk("resp_stable", {12'd0, ifc.resp_id, ifc.resp_S, ifc.resp_Cout, ifc.resp_err},
                             {12'd0, held.id, held.s, held.cout, held.err});
        end
        if (ifc.resp_ready) begin
          if (q_exp.size() != 0) q_exp.delete(0);
          m_ptr = (32'(ifc.resp_id) + 1) % NUM_REQ;
        end
      end
      prev_rv = ifc.resp_valid && !ifc.resp_ready;
    end
  end

  function automatic bit all_req_empty();
    for (int i = 0; i < NUM_REQ; i++) if (q_req[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_op(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    op_t o;
    o.a = a; o.b = b; o.cin = cin;
    q_req[r].push_back(o);
  endtask

  task automatic push_rand(input int r);
    push_op(r, N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    bit fin = 1'b0;
    while (!fin) begin
      @(negedge clk); #1;
      if (q_exp.size() == 0 && all_req_empty() && !ifc.busy && !ifc.resp_valid && ifc.req_valid == '0) fin = 1'b1;
      else if (++n >= budget) begin
        checks++; failures++;
        $display("FAIL wait_idle_%s: still busy after %0d cycles, expected idle", tag, budget);
        fin = 1'b1;
      end
    end
  endtask

  task automatic wait_resp_valid(input int budget, input string tag);
    int n = 0;
    while (!ifc.resp_valid && n < budget) begin @(negedge clk); n++; end
    if (!ifc.resp_valid) begin
      checks++; failures++;
      $display("FAIL wait_resp_%s: no resp_valid within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(ifc.req_ready), 32'd0);
    chk({tag, "_add_start"}, 32'(ifc.add_start), 32'd0);
    chk({tag, "_add_A"}, 32'(ifc.add_A), 32'd0);
    chk({tag, "_add_B"}, 32'(ifc.add_B), 32'd0);
    chk({tag, "_add_Cin"}, 32'(ifc.add_Cin), 32'd0);
    chk({tag, "_resp_valid"}, 32'(ifc.resp_valid), 32'd0);
    chk({tag, "_resp_fields"}, {12'd0, ifc.resp_id, ifc.resp_S, ifc.resp_Cout, ifc.resp_err}, 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst = 1'b0;

    push_op(0, 16'h1234, 16'h0FFF, 1'b0);
    wait_idle(100, "single");
    chk("single_S", 32'(last_S), 32'h2233);
    chk("single_meta", {29'd0, last_id, last_Cout}, 32'd0);
    chk("single_err", 32'(last_err), 32'd0);

    push_op(2, 16'hFFFF, 16'h0001, 1'b0);
    wait_idle(100, "carry");
    chk("carry_S", 32'(last_S), 32'h0000);
    chk("carry_Cout", 32'(last_Cout), 32'd1);
    chk("carry_id", 32'(last_id), 32'd2);

    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NUM_REQ; r++) push_rand(r);
    wait_idle(400, "all_four");

    rr_fixed = 1'b0;
    push_rand(3);
    wait_resp_valid(50, "backpressure");
    push_rand(0);
    repeat (10) @(negedge clk);
    rr_fixed = 1'b1;
    wait_idle(200, "backpressure");

    rr_rand = 1'b1;
    for (int k = 0; k < 24; k++) push_rand(int'($urandom_range(0, NUM_REQ - 1)));
    wait_idle(3000, "random");
    rr_rand = 1'b0;

    dead = 1'b1; rr_fixed = 1'b0;
    push_rand(1);
    wait_resp_valid(60, "timeout");
    repeat (2) @(posedge clk);
    #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    repeat (3) @(negedge clk);
    rr_fixed = 1'b1;
    wait_idle(100, "timeout");
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_done_ignored", {30'd0, ifc.resp_valid, ifc.busy}, 32'd0);
    dead = 1'b0;

    push_rand(1);
    n = 0;
    while (!ifc.add_start && n < 50) begin @(negedge clk); n++; end
    chk("reset_wait_start_seen", 32'(ifc.add_start), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    q_exp.delete(); m_ptr = 0; inflight = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midop");
    @(posedge clk); #1 rst = 1'b0;
    push_rand(3);
    push_rand(2);
    wait_resp_valid(50, "post_reset");
    chk("post_reset_first_id", 32'(ifc.resp_id), 32'd2);
    chk("post_reset_err", 32'(ifc.resp_err), 32'd0);
    wait_idle(200, "post_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares a single digit-serial adder (`carry_shifting_adder_optimized`, or the `adaptive_adder_wrapper` around it) among `NUM_REQ` requesters. It accepts one operand set per grant and drives the adder's `start`/`done` protocol. It returns sum and carry on a single response channel tagged with the requester ID. A watchdog converts a missing `done` into an error response, so a requester can never hang.

## Interface
- `N`, 16: operand width; must match the shared adder's `N`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the response ID.
- `TIMEOUT`, 64: cycles spent in WAIT without `add_done` before an error response; ≥ 2.

- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset; the same net also drives the adder's `rst`.
- `req_valid`  in  NUM_REQ  requester i holds operands valid.
- `req_ready`  out  NUM_REQ  one-hot grant; a handshake completes on an edge with `req_valid[i] && req_ready[i]`.
- `req_A`, `req_B`  in  NUM_REQ*N  packed operands; slot i is at `[i*N +: N]`.
- `req_Cin`  in  NUM_REQ  per-requester carry-in.
- `add_start`  out  1  start pulse to the adder.
- `add_A`, `add_B`  out  N  operands to the adder; held stable from ISSUE through WAIT.
- `add_Cin`  out  1  carry-in to the adder.
- `add_S`  in  N  adder sum; registered in the adder.
- `add_Cout`  in  1  adder carry-out.
- `add_done`  in  1  adder one-cycle completion pulse.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  ID_W  index of the requester served.
- `resp_S`  out  N  returned sum.
- `resp_Cout`  out  1  returned carry-out.
- `resp_err`  out  1  1 = timeout; in that case `resp_S` = 0 and `resp_Cout` = 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The state machine has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - `req_ready` is the combinational one-hot output of a round-robin pick over `req_valid`, searched starting at `rr_ptr`.
  - `req_ready` is all-zero outside IDLE and when no `req_valid` bit is set.
  - On a handshake:
    - latch the operands and `Cin` into `add_A`, `add_B`, `add_Cin`;
    - latch the grant index into `gnt_id`;
    - go to ISSUE.
- **ISSUE**
  - `add_start` = 1 for exactly this one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - On `add_done`:
    - capture `add_S` and `add_Cout` into `resp_S` and `resp_Cout`;
    - set `resp_err` = 0 and `resp_valid` = 1;
    - go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT - 1` without `add_done`:
    - set `resp_valid` = 1, `resp_err` = 1, `resp_S` = 0, `resp_Cout` = 0;
    - go to RESP.
  - If both conditions occur in the same cycle, `add_done` wins.
- **RESP**
  - Hold all `resp_*` outputs stable while `resp_ready` = 0.
  - On `resp_valid && resp_ready`:
    - clear `resp_valid`;
    - set `rr_ptr` = (`gnt_id` + 1) mod `NUM_REQ`;
    - go to IDLE.
- `add_done` is ignored in every state except WAIT. A late `done` after a timeout is discarded.
- `resp_id` = `gnt_id` whenever `resp_valid` = 1.
- Fairness: a continuously asserted requester waits at most `NUM_REQ - 1` services.
- Reset, including reset asserted mid-operation, sets:
  - state = IDLE, `rr_ptr` = 0;
  - `req_ready` = 0, `add_start` = 0;
  - `add_A` = 0, `add_B` = 0, `add_Cin` = 0;
  - `resp_valid` = 0, `resp_id` = 0, `resp_S` = 0, `resp_Cout` = 0, `resp_err` = 0;
  - `busy` = 0.
- Any operation in flight at reset is dropped without a response.

## Timing
- Let edge E0 be the accept handshake.
  - `add_start` is high in the cycle after E0 and is sampled by the adder at E1.
  - The adder runs ITER = ceil(N/K) active edges and raises `done` after E(1+ITER).
  - `resp_valid` rises after E(2+ITER).
- Accept-to-response latency is ITER + 2 cycles.
  - Example: N = 16, K = 6 gives ITER = 3, so latency = 5 cycles.
- Back-to-back throughput: the earliest next accept is the edge after the response handshake. That is one request per ITER + 4 cycles when `resp_ready` is held at 1.
- `add_start` never coincides with the adder being active. This is guaranteed because ISSUE is entered only from IDLE.

## Structure
- Shared package `adder_share_pkg` holds:
  - the state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3);
  - the default `TIMEOUT`;
  - the ID-width helper, which returns a minimum of 1.
- One sub-module, `rr_priority_picker`, implements the round-robin pick:
  - inputs: `req[NUM_REQ]` and `ptr`;
  - outputs: one-hot `gnt` and `gnt_idx`;
  - purely combinational.
- The adder itself is instantiated outside this block.

## Test plan
- Single requester 0: A = 16'h1234, B = 16'h0FFF, Cin = 0 → `resp_S` = 16'h2233, `resp_Cout` = 0, `resp_id` = 0, `resp_err` = 0, latency = ITER + 2.
- Carry propagation: requester 2, A = 16'hFFFF, B = 16'h0001, Cin = 0 → `resp_S` = 16'h0000, `resp_Cout` = 1, `resp_id` = 2.
- All four requesters held valid with distinct operands → served in order 0, 1, 2, 3, then 0 again. Each sum is correct and each `req_ready` is a single-cycle pulse.
- Backpressure: hold `resp_ready` = 0 for 10 cycles in RESP → response fields unchanged, `req_ready` stays 0, no `add_start`.
- Timeout: stub adder never asserts `done`, `TIMEOUT` = 8 → error response (`resp_err` = 1, `resp_S` = 0) 8 cycles after ISSUE. A late `add_done` injected afterwards is ignored.
- Reset asserted in WAIT → all outputs return to their reset values on the next edge. The next request completes normally with `rr_ptr` = 0.
